// File: rtl/carrd_dispatch_if.sv
// rtl/carrd_dispatch_if.sv - base-processor, coprocessor and result channels of the Carrd issue unit
interface carrd_dispatch_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_instr;
    logic [31:0] s_rs1;
    logic        s_wb_x;
    logic        c_valid;
    logic [31:0] c_instr;
    logic [31:0] c_x_data;
    logic        c_done;
    logic [31:0] c_x_data_in;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;

    modport master (
        output s_valid, s_instr, s_rs1, s_wb_x, c_done, c_x_data_in, r_ready,
        input  s_ready, c_valid, c_instr, c_x_data, r_valid, r_data
    );

    modport slave (
        input  s_valid, s_instr, s_rs1, s_wb_x, c_done, c_x_data_in, r_ready,
        output s_ready, c_valid, c_instr, c_x_data, r_valid, r_data
    );
endinterface

// File: rtl/carrd_dispatch.sv
// rtl/carrd_dispatch.sv - scalar-side issue unit: instruction FIFO, single in-flight issue, scalar result return
module carrd_dispatch #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    carrd_dispatch_if.slave  bus,
    output logic             busy,
    output logic [CNT_W-1:0] q_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      mem_instr [DEPTH];
    logic [31:0]      mem_rs1   [DEPTH];
    logic             mem_wb_x  [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic        c_valid_q;
    logic [31:0] c_instr_q, c_x_data_q;
    logic        cur_wb_x, cur_cfg;
    logic        r_valid_q;
    logic [31:0] r_data_q;

    logic        push, pop, head_cfg;
    logic [31:0] head_instr;

    assign bus.s_ready = (count != CNT_W'(DEPTH));
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = (state_q == ST_IDLE) && (count != '0);
    assign head_instr  = mem_instr[rd_ptr];
    // vsetvli/vsetivli finish in the coprocessor CSR in a single cycle without c_done
    assign head_cfg    = (head_instr[6:0] == 7'b1010111) && (head_instr[14:12] == 3'b111);

    assign bus.c_valid  = c_valid_q;
    assign bus.c_instr  = c_instr_q;
    assign bus.c_x_data = c_x_data_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_data   = r_data_q;
    assign q_count      = count;
    assign busy         = (state_q != ST_IDLE) || (count != '0);

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= bus.s_instr;
            mem_rs1[wr_ptr]   <= bus.s_rs1;
            mem_wb_x[wr_ptr]  <= bus.s_wb_x;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; config instructions take priority over a coincident c_done
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (count != '0) state_d = ST_WAIT;
            ST_WAIT: begin
                if (cur_cfg)         state_d = ST_IDLE;
                else if (bus.c_done) state_d = cur_wb_x ? ST_RESP : ST_IDLE;
            end
            ST_RESP: if (bus.r_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue registers: load on pop, hold through WAIT, clear on the edge leaving WAIT
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            c_valid_q  <= 1'b0;
            c_instr_q  <= '0;
            c_x_data_q <= '0;
            cur_wb_x   <= 1'b0;
            cur_cfg    <= 1'b0;
        end else if (pop) begin
            c_valid_q  <= 1'b1;
            c_instr_q  <= head_instr;
            c_x_data_q <= mem_rs1[rd_ptr];
            cur_wb_x   <= mem_wb_x[rd_ptr];
            cur_cfg    <= head_cfg;
        end else if ((state_q == ST_WAIT) && (state_d != ST_WAIT)) begin
            c_valid_q  <= 1'b0;
            c_instr_q  <= '0;
            c_x_data_q <= '0;
        end
    end

    // Scalar result: captured with c_done, held until the base processor takes it
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else if ((state_q == ST_WAIT) && (state_d == ST_RESP)) begin
            r_valid_q <= 1'b1;
            r_data_q  <= bus.c_x_data_in;
        end else if ((state_q == ST_RESP) && bus.r_ready) begin
            r_valid_q <= 1'b0;
        end
    end
endmodule
